vga_line_fetch_sched: RTL and testbench

Scheduler that feeds a ping-pong line buffer from frame memory in step with the VGA timing generator. It watches the generator's `hpos`/`vpos`. At the start of horizontal blanking it issues a burst of word reads for the next visible line, and it steers the returned data into the buffer bank that line will use. It sits between the VGA timing block, the memory read port and the pixel mixer.

---
 rtl/vga_fetch_pkg.sv | 25 ++
 rtl/vga_line_fetch_sched.sv | 212 +++++++++++++++++++++
 tb/tb_vga_line_fetch_sched.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fetch_pkg.sv
// ---------------------------------------------------------------------------
// vga_fetch_pkg
// Shared types and default timing constants for the VGA line-fetch scheduler
// and the VGA timing generator it follows.
//   fetch_state_t : scheduler FSM states (IDLE, REQ, DRAIN)
//   *_DEF         : default 640x480 timing and line-fetch geometry
// ---------------------------------------------------------------------------
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

    localparam int HPOS_WIDTH_DEF     = 10;
    localparam int VPOS_WIDTH_DEF     = 10;
    localparam int H_DISPLAY_DEF      = 640;
    localparam int V_DISPLAY_DEF      = 480;
    localparam int V_TOTAL_DEF        = 525;
    localparam int WORDS_PER_LINE_DEF = 40;
    localparam int ADDR_WIDTH_DEF     = 16;
    localparam int DATA_WIDTH_DEF     = 16;

endpackage

// File: rtl/vga_line_fetch_sched.sv
// ---------------------------------------------------------------------------
// vga_line_fetch_sched
// Fetches the next visible line from frame memory into a ping-pong line
// buffer. At the start of horizontal blanking it bursts WORDS_PER_LINE word
// reads and steers the in-order read data into the bank the target line uses.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   hpos, vpos        beam position from the timing generator
//   fb_base           frame base address, sampled at hpos==0 of the last line
//   mem_req/addr/gnt  read address channel (address held until granted)
//   mem_rvalid/rdata  read data channel, in request order
//   lb_we/waddr/wdata registered line-buffer write port, waddr = {bank, index}
//   rd_bank           bank the display side reads (registered vpos[0])
//   underrun          sticky: a fetch was still busy when its line started
//   underrun_clr      clears underrun (a simultaneous set wins)
//   underrun_cnt      saturating underrun event count, only when
//                     VGA_LINE_FETCH_UNDERRUN_CNT_EN is defined
// ---------------------------------------------------------------------------
module vga_line_fetch_sched
    import vga_fetch_pkg::*;
#(
    parameter int HPOS_WIDTH     = HPOS_WIDTH_DEF,
    parameter int VPOS_WIDTH     = VPOS_WIDTH_DEF,
    parameter int H_DISPLAY      = H_DISPLAY_DEF,
    parameter int V_DISPLAY      = V_DISPLAY_DEF,
    parameter int V_TOTAL        = V_TOTAL_DEF,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [HPOS_WIDTH-1:0]               hpos,
    input  logic [VPOS_WIDTH-1:0]               vpos,
    input  logic [ADDR_WIDTH-1:0]               fb_base,
    output logic                                mem_req,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    input  logic                                mem_gnt,
    input  logic                                mem_rvalid,
    input  logic [DATA_WIDTH-1:0]               mem_rdata,
    output logic                                lb_we,
    output logic [$clog2(WORDS_PER_LINE):0]     lb_waddr,
    output logic [DATA_WIDTH-1:0]               lb_wdata,
    output logic                                rd_bank,
    output logic                                underrun,
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
    output logic [7:0]                          underrun_cnt,
`endif
    input  logic                                underrun_clr
);

    localparam int CNT_W = $clog2(WORDS_PER_LINE + 1);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);

    localparam logic [HPOS_WIDTH-1:0] H_TRIG    = HPOS_WIDTH'(H_DISPLAY);
    localparam logic [VPOS_WIDTH-1:0] V_TRIG_LT = VPOS_WIDTH'(V_DISPLAY - 1);
    localparam logic [VPOS_WIDTH-1:0] V_LAST    = VPOS_WIDTH'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]      WPL_CNT   = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0]      WPL_LAST  = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] WPL_ADDR  = ADDR_WIDTH'(WORDS_PER_LINE);

    fetch_state_t                 state_q,     state_d;
    logic [CNT_W-1:0]             req_cnt_q,   req_cnt_d;
    logic [CNT_W-1:0]             rcv_cnt_q,   rcv_cnt_d;
    logic [ADDR_WIDTH-1:0]        line_base_q, line_base_d;
    logic                         bank_q,      bank_d;
    logic [VPOS_WIDTH-1:0]        tgt_line_q,  tgt_line_d;
    logic                         lb_we_q,     lb_we_d;
    logic [IDX_W:0]               lb_waddr_q,  lb_waddr_d;
    logic [DATA_WIDTH-1:0]        lb_wdata_q,  lb_wdata_d;
    logic                         rd_bank_q,   rd_bank_d;
    logic                         underrun_q,  underrun_d;
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
    logic [7:0]                   ur_cnt_q,    ur_cnt_d;
`endif

    logic                  trigger;
    logic [VPOS_WIDTH-1:0] trig_line;
    logic                  frame_start;
    logic                  underrun_set;
    logic                  beat;

    // Line 0 is fetched during the blanking of the frame's last line; every
    // other visible line is fetched during the blanking of the line before it.
    assign trigger      = (hpos == H_TRIG) && ((vpos < V_TRIG_LT) || (vpos == V_LAST));
    assign trig_line    = (vpos == V_LAST) ? '0 : vpos + VPOS_WIDTH'(1);
    assign frame_start  = (hpos == '0) && (vpos == V_LAST);
    assign underrun_set = (state_q != IDLE) && (hpos == '0) && (vpos == tgt_line_q);
    // Returns outside a fetch (e.g. stragglers after reset) are dropped here.
    assign beat         = mem_rvalid && (state_q != IDLE) && (rcv_cnt_q != WPL_CNT);

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the branches below can leave one unassigned and infer a latch.
        state_d     = state_q;
        req_cnt_d   = req_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        line_base_d = line_base_q;
        bank_d      = bank_q;
        tgt_line_d  = tgt_line_q;

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d    = REQ;
                    bank_d     = trig_line[0];
                    tgt_line_d = trig_line;
                    req_cnt_d  = '0;
                    rcv_cnt_d  = '0;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    req_cnt_d = req_cnt_q + CNT_W'(1);
                    if (req_cnt_q == WPL_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rcv_cnt_q == WPL_CNT) begin
                    state_d     = IDLE;
                    line_base_d = line_base_q + WPL_ADDR;
                end
            end
            default: state_d = IDLE;
        endcase

        if (beat) begin
            rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
        end

        // A new frame base overrides any per-line advance in the same cycle.
        if (frame_start) begin
            line_base_d = fb_base;
        end
    end

    always_comb begin
        lb_we_d    = beat;
        lb_waddr_d = beat ? {bank_q, rcv_cnt_q[IDX_W-1:0]} : lb_waddr_q;
        lb_wdata_d = beat ? mem_rdata : lb_wdata_q;
        rd_bank_d  = vpos[0];

        underrun_d = underrun_q;
        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end

`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
        ur_cnt_d = ur_cnt_q;
        if (underrun_set) begin
            ur_cnt_d = (ur_cnt_q == 8'hFF) ? ur_cnt_q : ur_cnt_q + 8'd1;
        end else if (underrun_clr) begin
            ur_cnt_d = '0;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, whatever the order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_cnt_q   <= '0;
            rcv_cnt_q   <= '0;
            line_base_q <= '0;
            bank_q      <= 1'b0;
            tgt_line_q  <= '0;
            lb_we_q     <= 1'b0;
            lb_waddr_q  <= '0;
            lb_wdata_q  <= '0;
            rd_bank_q   <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
            ur_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_cnt_q   <= req_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            line_base_q <= line_base_d;
            bank_q      <= bank_d;
            tgt_line_q  <= tgt_line_d;
            lb_we_q     <= lb_we_d;
            lb_waddr_q  <= lb_waddr_d;
            lb_wdata_q  <= lb_wdata_d;
            rd_bank_q   <= rd_bank_d;
            underrun_q  <= underrun_d;
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
            ur_cnt_q    <= ur_cnt_d;
`endif
        end
    end

    // The request is a pure function of registered state, so it stays
    // stable while the memory withholds its grant.
    assign mem_req  = (state_q == REQ);
    assign mem_addr = line_base_q + ADDR_WIDTH'(req_cnt_q);
    assign lb_we    = lb_we_q;
    assign lb_waddr = lb_waddr_q;
    assign lb_wdata = lb_wdata_q;
    assign rd_bank  = rd_bank_q;
    assign underrun = underrun_q;
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
    assign underrun_cnt = ur_cnt_q;
`endif

endmodule

// File: tb/tb_vga_line_fetch_sched.sv
// ---------------------------------------------------------------------------
// tb_vga_line_fetch_sched
// Directed bench for vga_line_fetch_sched. Beam position is driven directly
// to the interesting hpos/vpos points instead of sweeping whole frames. A
// small in-bench memory responder returns addr ^ 16'h5A5A a fixed number of
// cycles after each grant; all expected addresses, banks and data are derived
// from the frame base and line number written into each test.
// ---------------------------------------------------------------------------
module tb_vga_line_fetch_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic [15:0] fb_base;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        lb_we;
    logic [6:0]  lb_waddr;
    logic [15:0] lb_wdata;
    logic        rd_bank;
    logic        underrun;
    logic        underrun_clr;
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_line_fetch_sched dut (
        .clk          (clk),
        .reset        (reset),
        .hpos         (hpos),
        .vpos         (vpos),
        .fb_base      (fb_base),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .lb_we        (lb_we),
        .lb_waddr     (lb_waddr),
        .lb_wdata     (lb_wdata),
        .rd_bank      (rd_bank),
        .underrun     (underrun),
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .underrun_clr (underrun_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Triggers a fetch from line trig_line and runs it to completion.
    // stall: grant-free cycles before the first grant; lat: grant-to-data
    // latency; ur_at >= 0 presents hpos=0/vpos=ur_line (with underrun_clr)
    // at that loop cycle.
    task automatic do_fetch(input string name, input logic [9:0] trig_line,
                            input logic [15:0] base, input logic bank,
                            input int stall, input int lat,
                            input int ur_at, input logic [9:0] ur_line);
        logic [15:0] wdat [40];
        int          due_q[$];
        int          n_gnt, n_we, n_rv, stalled, cyc;
        logic [15:0] exp_addr;
        n_gnt = 0; n_we = 0; n_rv = 0; stalled = 0; cyc = 0;

        hpos = 10'd640; vpos = trig_line; mem_rvalid = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s pre_trigger_req: got %b want 0", name, mem_req);
        end
        tick();
        hpos = 10'd641;

        while (cyc < 300 && !(n_gnt == 40 && n_we == 40 && due_q.size() == 0)) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; underrun_clr = 1'b0;
            if (ur_at >= 0 && cyc == ur_at) begin
                hpos = 10'd0; vpos = ur_line; underrun_clr = 1'b1;
            end else if (ur_at >= 0 && cyc == ur_at + 1) begin
                hpos = 10'd1;
            end

            if (lb_we === 1'b1) begin
                checks++;
                if (n_we >= 40) begin
                    errors++;
                    $display("FAIL %s extra_lb_we: beat %0d beyond 40", name, n_we);
                end else if (lb_waddr !== {bank, 6'(n_we)} || lb_wdata !== wdat[n_we]) begin
                    errors++;
                    $display("FAIL %s lb_write[%0d]: got addr %h data %h want addr %h data %h",
                             name, n_we, lb_waddr, lb_wdata, {bank, 6'(n_we)}, wdat[n_we]);
                end
                n_we++;
            end

            checks++;
            if (n_gnt < 40) begin
                exp_addr = base + 16'(n_gnt);
                if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL %s request[%0d] cyc %0d: got req %b addr %h want req 1 addr %h",
                             name, n_gnt, cyc, mem_req, mem_addr, exp_addr);
                end
                if (stalled < stall) begin
                    stalled++;
                end else begin
                    mem_gnt = 1'b1;
                    wdat[n_gnt] = exp_addr ^ 16'h5A5A;
                    due_q.push_back(cyc + lat);
                    n_gnt++;
                end
            end else if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL %s req_after_last_grant: got %b want 0", name, mem_req);
            end

            if (due_q.size() > 0 && due_q[0] == cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = wdat[n_rv];
                n_rv++;
                void'(due_q.pop_front());
            end
            tick();
            cyc++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; underrun_clr = 1'b0;

        checks++;
        if (n_gnt != 40 || n_we != 40) begin
            errors++;
            $display("FAIL %s completion: got %0d grants %0d writes want 40 40", name, n_gnt, n_we);
        end
        checks++;
        if (lb_we !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s quiet_after: got lb_we %b req %b want 0 0", name, lb_we, mem_req);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; hpos = 10'd0; vpos = 10'd1; fb_base = 16'hABCD;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hFFFF; underrun_clr = 1'b0;
        repeat (3) tick();
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_req: got req %b addr %h want 0 0000", mem_req, mem_addr);
        end
        checks++;
        if (lb_we !== 1'b0 || lb_waddr !== 7'd0 || lb_wdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_lb: got we %b addr %h data %h want 0 00 0000", lb_we, lb_waddr, lb_wdata);
        end
        checks++;
        if (rd_bank !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got rd_bank %b underrun %b want 0 0", rd_bank, underrun);
        end
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
        checks++;
        if (underrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_ur_cnt: got %0d want 0", underrun_cnt);
        end
`endif
        reset = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; vpos = 10'd0;
        tick();
    endtask

    task automatic test_first_frame();
        hpos = 10'd0; vpos = 10'd524; fb_base = 16'h1000;
        tick();
        fb_base = 16'h7777;   // must not be picked up until the next frame start
        do_fetch("first_frame", 10'd524, 16'h1000, 1'b0, 0, 1, -1, 10'd0);
    endtask

    task automatic test_line0();
        do_fetch("line0", 10'd0, 16'h1028, 1'b1, 0, 1, -1, 10'd0);
    endtask

    task automatic test_no_trigger();
        logic [9:0] lines [5];
        lines = '{10'd479, 10'd480, 10'd501, 10'd523, 10'd5};
        foreach (lines[i]) begin
            hpos = (i == 4) ? 10'd639 : 10'd640;
            vpos = lines[i];
            tick();
            hpos = 10'd641;
            tick();
            checks++;
            if (mem_req !== 1'b0 || rd_bank !== lines[i][0]) begin
                errors++;
                $display("FAIL no_trigger vpos %0d: got req %b rd_bank %b want 0 %b",
                         lines[i], mem_req, rd_bank, lines[i][0]);
            end
        end
        // Last line that does trigger: target 479, bank 1, base unchanged by the idle lines.
        do_fetch("line478", 10'd478, 16'h1050, 1'b1, 0, 2, -1, 10'd0);
    endtask

    task automatic test_back_pressure();
        hpos = 10'd641; vpos = 10'd1; mem_gnt = 1'b1;   // grants while idle are ignored
        repeat (3) tick();
        do_fetch("back_pressure", 10'd1, 16'h1078, 1'b0, 5, 3, -1, 10'd0);
    endtask

    task automatic test_underrun();
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_pre: got %b want 0", underrun);
        end
        // Line 3 starts while the fetch is stalled; clear is asserted in the same cycle.
        do_fetch("underrun", 10'd2, 16'h10A0, 1'b1, 20, 2, 8, 10'd3);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_set: got %b want 1", underrun);
        end
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
        checks++;
        if (underrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL underrun_cnt: got %0d want 1", underrun_cnt);
        end
`endif
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clr: got %b want 0", underrun);
        end
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
        checks++;
        if (underrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL underrun_cnt_clr: got %0d want 0", underrun_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] exp_addr;
        hpos = 10'd640; vpos = 10'd3;
        tick();
        hpos = 10'd641;
        for (int i = 0; i < 10; i++) begin
            exp_addr = 16'h10C8 + 16'(i);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL mid_burst_req[%0d]: got req %b addr %h want 1 %h", i, mem_req, mem_addr, exp_addr);
            end
            mem_gnt = 1'b1;
            tick();
        end
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        checks++;
        if (mem_req !== 1'b0 || lb_we !== 1'b0 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL mid_burst_reset: got req %b we %b addr %h want 0 0 0000", mem_req, lb_we, mem_addr);
        end
        reset = 1'b0; mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (lb_we !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL stray_rvalid[%0d]: got we %b req %b want 0 0", i, lb_we, mem_req);
            end
        end
        mem_rvalid = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        hpos = 10'd0; vpos = 10'd524; fb_base = 16'hFFF0;
        tick();
        fb_base = 16'h0000;
        do_fetch("wrap", 10'd524, 16'hFFF0, 1'b0, 0, 2, -1, 10'd0);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_line0();
        test_no_trigger();
        test_back_pressure();
        test_underrun();
        test_reset_mid_burst();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
